// File: rtl/operand_address_translator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : operand_address_translator                                       |
// | Purpose : per-thread operand address translation (base offset, indirect    |
// |           pointer slots with post-increment), 2-cycle pipeline             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module operand_address_translator #(
  parameter int ADDR_WIDTH         = 10,
  parameter int WORD_WIDTH         = 36,
  parameter int OD_WORD_WIDTH      = 20,
  parameter int THREAD_COUNT       = 8,
  parameter int THREAD_COUNT_WIDTH = 3,
  parameter int SHARED_LIMIT       = 32,
  parameter int PTR_BASE           = 24,
  parameter int CFG_BASE           = 512
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     config_write,
  input  logic [ADDR_WIDTH-1:0]    config_addr,
  input  logic [WORD_WIDTH-1:0]    config_data,
  input  logic [OD_WORD_WIDTH-1:0] ALU_control_in,
  input  logic [ADDR_WIDTH-1:0]    DA_in,
  input  logic [ADDR_WIDTH-1:0]    DB_in,
  input  logic [ADDR_WIDTH-1:0]    A_in,
  input  logic [ADDR_WIDTH-1:0]    B_in,
  input  logic                     annul,
  output logic [OD_WORD_WIDTH-1:0] ALU_control,
  output logic [ADDR_WIDTH-1:0]    DA,
  output logic [ADDR_WIDTH-1:0]    DB,
  output logic [ADDR_WIDTH-1:0]    A,
  output logic [ADDR_WIDTH-1:0]    B
);

  localparam int                  c_cfg_end_i = CFG_BASE + 8 * THREAD_COUNT;
  localparam int                  c_ptr1_i    = PTR_BASE + 1;
  localparam logic [ADDR_WIDTH:0] c_cfg_lo    = CFG_BASE[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] c_cfg_hi    = c_cfg_end_i[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH-1:0] c_ptr0    = PTR_BASE[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] c_ptr1    = c_ptr1_i[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] c_shared  = SHARED_LIMIT[ADDR_WIDTH-1:0];

  logic [THREAD_COUNT_WIDTH-1:0] r_thread;

  logic [ADDR_WIDTH-1:0] r_ofs  [THREAD_COUNT];
  logic [ADDR_WIDTH-1:0] r_ptr0 [THREAD_COUNT];
  logic [ADDR_WIDTH-1:0] r_ptr1 [THREAD_COUNT];
  logic [ADDR_WIDTH-1:0] r_inc0 [THREAD_COUNT];
  logic [ADDR_WIDTH-1:0] r_inc1 [THREAD_COUNT];

  logic                          r_s1_valid;
  logic [THREAD_COUNT_WIDTH-1:0] r_s1_tid;
  logic [OD_WORD_WIDTH-1:0]      r_s1_alu;
  logic [ADDR_WIDTH-1:0]         r_s1_da, r_s1_db, r_s1_a, r_s1_b;
  logic [ADDR_WIDTH-1:0]         r_s1_ofs, r_s1_ptr0, r_s1_ptr1;

  logic [ADDR_WIDTH-1:0]         w_cfg_off;
  logic                          w_cfg_hit;
  logic [THREAD_COUNT_WIDTH-1:0] w_cfg_tid;
  logic [2:0]                    w_cfg_sel;
  logic [ADDR_WIDTH-1:0]         w_cfg_val;
  logic                          w_unused_bits;
  logic                          w_ref0, w_ref1, w_inc0_en, w_inc1_en;
  logic [ADDR_WIDTH-1:0]         w_da, w_db, w_a, w_b;

  function automatic logic [ADDR_WIDTH-1:0] f_xlate(
    input logic [ADDR_WIDTH-1:0] x,
    input logic [ADDR_WIDTH-1:0] ofs,
    input logic [ADDR_WIDTH-1:0] p0,
    input logic [ADDR_WIDTH-1:0] p1
  );
    if (x == c_ptr0)        return p0;
    else if (x == c_ptr1)   return p1;
    else if (x < c_shared)  return x;
    else                    return x + ofs;
  endfunction

  // Config address decode: 8 table slots per thread starting at CFG_BASE
  assign w_cfg_off     = config_addr - c_cfg_lo[ADDR_WIDTH-1:0];
  assign w_cfg_hit     = config_write && ({1'b0, config_addr} >= c_cfg_lo)
                                      && ({1'b0, config_addr} <  c_cfg_hi);
  assign w_cfg_tid     = w_cfg_off[THREAD_COUNT_WIDTH+2:3];
  assign w_cfg_sel     = w_cfg_off[2:0];
  assign w_cfg_val     = config_data[ADDR_WIDTH-1:0];
  assign w_unused_bits = ^{config_data[WORD_WIDTH-1:ADDR_WIDTH],
                           w_cfg_off[ADDR_WIDTH-1:THREAD_COUNT_WIDTH+3]};

  assign w_da = f_xlate(r_s1_da, r_s1_ofs, r_s1_ptr0, r_s1_ptr1);
  assign w_db = f_xlate(r_s1_db, r_s1_ofs, r_s1_ptr0, r_s1_ptr1);
  assign w_a  = f_xlate(r_s1_a,  r_s1_ofs, r_s1_ptr0, r_s1_ptr1);
  assign w_b  = f_xlate(r_s1_b,  r_s1_ofs, r_s1_ptr0, r_s1_ptr1);

  assign w_ref0    = (r_s1_da == c_ptr0) || (r_s1_db == c_ptr0) ||
                     (r_s1_a  == c_ptr0) || (r_s1_b  == c_ptr0);
  assign w_ref1    = (r_s1_da == c_ptr1) || (r_s1_db == c_ptr1) ||
                     (r_s1_a  == c_ptr1) || (r_s1_b  == c_ptr1);
  assign w_inc0_en = r_s1_valid && !annul && w_ref0;
  assign w_inc1_en = r_s1_valid && !annul && w_ref1;

  always_ff @(posedge clock) begin
    if (reset) r_thread <= '0;
    else       r_thread <= r_thread + THREAD_COUNT_WIDTH'(1);
  end

  // Config write is applied after the increment so it wins on a collision
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < THREAD_COUNT; i++) begin
        r_ofs[i]  <= '0;
        r_ptr0[i] <= '0;
        r_ptr1[i] <= '0;
        r_inc0[i] <= '0;
        r_inc1[i] <= '0;
      end
    end else begin
      if (w_inc0_en) r_ptr0[r_s1_tid] <= r_ptr0[r_s1_tid] + r_inc0[r_s1_tid];
      if (w_inc1_en) r_ptr1[r_s1_tid] <= r_ptr1[r_s1_tid] + r_inc1[r_s1_tid];
      if (w_cfg_hit) begin
        case (w_cfg_sel)
          3'd0:    r_ofs[w_cfg_tid]  <= w_cfg_val;
          3'd1:    r_ptr0[w_cfg_tid] <= w_cfg_val;
          3'd2:    r_ptr1[w_cfg_tid] <= w_cfg_val;
          3'd3:    r_inc0[w_cfg_tid] <= w_cfg_val;
          3'd4:    r_inc1[w_cfg_tid] <= w_cfg_val;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_tid   <= '0;
      r_s1_alu   <= '0;
      r_s1_da    <= '0;
      r_s1_db    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_ofs   <= '0;
      r_s1_ptr0  <= '0;
      r_s1_ptr1  <= '0;
    end else begin
      r_s1_valid <= 1'b1;
      r_s1_tid   <= r_thread;
      r_s1_alu   <= ALU_control_in;
      r_s1_da    <= DA_in;
      r_s1_db    <= DB_in;
      r_s1_a     <= A_in;
      r_s1_b     <= B_in;
      r_s1_ofs   <= r_ofs[r_thread];
      r_s1_ptr0  <= r_ptr0[r_thread];
      r_s1_ptr1  <= r_ptr1[r_thread];
    end
  end

  always_ff @(posedge clock) begin
    if (reset || !r_s1_valid) begin
      ALU_control <= '0;
      DA          <= '0;
      DB          <= '0;
      A           <= '0;
      B           <= '0;
    end else begin
      ALU_control <= r_s1_alu;
      DA          <= w_da;
      DB          <= w_db;
      A           <= w_a;
      B           <= w_b;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_operand_address_translator.sv
`default_nettype none
// Bench for operand_address_translator: directed test-plan scenarios plus
// random traffic, all checked against a cycle-level reference model.
module tb_operand_address_translator;

  localparam int AW  = 10;
  localparam int OW  = 20;
  localparam int TC  = 8;
  localparam int CFG = 512;
  localparam int PB  = 24;
  localparam int SL  = 32;

  logic           clock = 1'b0;
  logic           reset;
  logic           config_write;
  logic [AW-1:0]  config_addr;
  logic [35:0]    config_data;
  logic [OW-1:0]  alu_in;
  logic [AW-1:0]  da_in, db_in, a_in, b_in;
  logic           annul;
  logic [OW-1:0]  alu_q;
  logic [AW-1:0]  da_q, db_q, a_q, b_q;

  int errors = 0;
  int checks = 0;

  operand_address_translator dut (
    .clock          (clock),
    .reset          (reset),
    .config_write   (config_write),
    .config_addr    (config_addr),
    .config_data    (config_data),
    .ALU_control_in (alu_in),
    .DA_in          (da_in),
    .DB_in          (db_in),
    .A_in           (a_in),
    .B_in           (b_in),
    .annul          (annul),
    .ALU_control    (alu_q),
    .DA             (da_q),
    .DB             (db_q),
    .A              (a_q),
    .B              (b_q)
  );

  always #5 clock = ~clock;

  // Reference model state
  logic [AW-1:0] m_ofs [TC];
  logic [AW-1:0] m_p0  [TC];
  logic [AW-1:0] m_p1  [TC];
  logic [AW-1:0] m_i0  [TC];
  logic [AW-1:0] m_i1  [TC];
  int            m_ctr;
  bit            s_v;
  int            s_t;
  logic [OW-1:0] s_alu;
  logic [AW-1:0] s_da, s_db, s_a, s_b, s_ofs, s_p0, s_p1;
  logic [OW-1:0] e_alu;
  logic [AW-1:0] e_da, e_db, e_a, e_b;

  function automatic logic [AW-1:0] xl(input logic [AW-1:0] x, input logic [AW-1:0] o,
                                       input logic [AW-1:0] q0, input logic [AW-1:0] q1);
    int xi = int'(x);
    if (xi == PB)     return q0;
    if (xi == PB + 1) return q1;
    if (xi < SL)      return x;
    return AW'((xi + int'(o)) % (1 << AW));
  endfunction

  task automatic m_edge();
    bit u0, u1;
    int addr;
    if (reset) begin
      for (int i = 0; i < TC; i++) begin
        m_ofs[i] = '0; m_p0[i] = '0; m_p1[i] = '0; m_i0[i] = '0; m_i1[i] = '0;
      end
      s_v = 0; m_ctr = 0;
      e_alu = '0; e_da = '0; e_db = '0; e_a = '0; e_b = '0;
    end else begin
      if (s_v) begin
        e_alu = s_alu;
        e_da = xl(s_da, s_ofs, s_p0, s_p1);
        e_db = xl(s_db, s_ofs, s_p0, s_p1);
        e_a  = xl(s_a,  s_ofs, s_p0, s_p1);
        e_b  = xl(s_b,  s_ofs, s_p0, s_p1);
      end else begin
        e_alu = '0; e_da = '0; e_db = '0; e_a = '0; e_b = '0;
      end
      u0 = s_v && !annul && (s_da == AW'(PB) || s_db == AW'(PB) || s_a == AW'(PB) || s_b == AW'(PB));
      u1 = s_v && !annul && (s_da == AW'(PB+1) || s_db == AW'(PB+1) ||
                             s_a == AW'(PB+1) || s_b == AW'(PB+1));
      // new instruction takes its table snapshot before this edge's updates
      s_ofs = m_ofs[m_ctr]; s_p0 = m_p0[m_ctr]; s_p1 = m_p1[m_ctr];
      if (u0) m_p0[s_t] = AW'((int'(m_p0[s_t]) + int'(m_i0[s_t])) % (1 << AW));
      if (u1) m_p1[s_t] = AW'((int'(m_p1[s_t]) + int'(m_i1[s_t])) % (1 << AW));
      addr = int'(config_addr);
      if (config_write && addr >= CFG && addr < CFG + 8 * TC) begin
        case ((addr - CFG) % 8)
          0: m_ofs[(addr - CFG) / 8] = config_data[AW-1:0];
          1: m_p0[(addr - CFG) / 8]  = config_data[AW-1:0];
          2: m_p1[(addr - CFG) / 8]  = config_data[AW-1:0];
          3: m_i0[(addr - CFG) / 8]  = config_data[AW-1:0];
          4: m_i1[(addr - CFG) / 8]  = config_data[AW-1:0];
          default: ;
        endcase
      end
      s_v = 1; s_t = m_ctr; s_alu = alu_in;
      s_da = da_in; s_db = db_in; s_a = a_in; s_b = b_in;
      m_ctr = (m_ctr + 1) % TC;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    m_edge();
    #1;
    chk("pipe", {4'b0, alu_q, da_q, db_q, a_q, b_q}, {4'b0, e_alu, e_da, e_db, e_a, e_b});
    config_write = 1'b0;
    da_in = '0; db_in = '0; a_in = '0; b_in = '0;
    alu_in = OW'($urandom);
    annul = 1'b0;
  endtask

  task automatic wait_thread(input int t);
    for (int i = 0; i < TC && m_ctr != t; i++) tick();
  endtask

  task automatic cfg(input int t, input int k, input int v);
    config_write = 1'b1;
    config_addr  = AW'(CFG + 8 * t + k);
    config_data  = {26'($urandom), AW'(v)};
    tick();
  endtask

  function automatic logic [AW-1:0] pick_op();
    case ($urandom_range(0, 3))
      0:       return AW'(PB);
      1:       return AW'(PB + 1);
      2:       return AW'($urandom_range(0, SL - 1));
      default: return AW'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b1; config_write = 1'b0; config_addr = '0; config_data = '0;
    alu_in = '0; da_in = '0; db_in = '0; a_in = '0; b_in = '0; annul = 1'b0;
    tick(); tick();
    chk("reset_out", {4'b0, alu_q, da_q, db_q, a_q, b_q}, 64'd0);
    reset = 1'b0;

    // Offset
    cfg(3, 0, 100);
    wait_thread(3); a_in = 10'd40; b_in = 10'd5; tick(); tick();
    chk("ofs_A", 64'(a_q), 64'd140);
    chk("ofs_B", 64'(b_q), 64'd5);
    wait_thread(4); a_in = 10'd40; tick(); tick();
    chk("ofs_other", 64'(a_q), 64'd40);

    // Pointer post-increment
    cfg(1, 1, 200); cfg(1, 3, 4);
    for (int i = 0; i < 3; i++) begin
      wait_thread(1); a_in = 10'd24; tick(); tick();
      chk("ptr_post", 64'(a_q), 64'(200 + 4 * i));
    end
    wait_thread(1); a_in = 10'd24; tick(); tick();
    chk("ptr_readback", 64'(a_q), 64'd212);

    // Shared slot increments once
    cfg(0, 2, 50); cfg(0, 4, 1);
    wait_thread(0); da_in = 10'd25; a_in = 10'd25; b_in = 10'd25; tick(); tick();
    chk("shared_DA", 64'(da_q), 64'd50);
    chk("shared_A", 64'(a_q), 64'd50);
    chk("shared_B", 64'(b_q), 64'd50);
    wait_thread(0); a_in = 10'd25; tick(); tick();
    chk("shared_once", 64'(a_q), 64'd51);

    // Annul and wrap
    cfg(2, 1, 1023); cfg(2, 3, 1);
    wait_thread(2); a_in = 10'd24; tick(); annul = 1'b1; tick();
    chk("annul_A", 64'(a_q), 64'd1023);
    wait_thread(2); a_in = 10'd24; tick(); tick();
    chk("annul_nochg", 64'(a_q), 64'd1023);
    wait_thread(2); a_in = 10'd24; tick(); tick();
    chk("wrap_up", 64'(a_q), 64'd0);
    cfg(2, 1, 0); cfg(2, 3, 10'h3FF);
    wait_thread(2); a_in = 10'd24; tick(); tick();
    chk("neg_inc0", 64'(a_q), 64'd0);
    wait_thread(2); a_in = 10'd24; tick(); tick();
    chk("wrap_down", 64'(a_q), 64'd1023);

    // Write/increment collision
    cfg(5, 1, 10); cfg(5, 3, 3);
    wait_thread(5); a_in = 10'd24; tick();
    cfg(5, 1, 77);
    chk("coll_A", 64'(a_q), 64'd10);
    wait_thread(5); a_in = 10'd24; tick(); tick();
    chk("coll_wins", 64'(a_q), 64'd77);

    // Reset mid-stream, then thread counter restarts at 0
    wait_thread(1); a_in = 10'd24; tick();
    reset = 1'b1; tick();
    chk("midreset_out", {4'b0, alu_q, da_q, db_q, a_q, b_q}, 64'd0);
    reset = 1'b0;
    cfg(2, 0, 100);
    tick();
    a_in = 10'd40; tick(); tick();
    chk("restart_thread", 64'(a_q), 64'd140);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      reset        = ($urandom_range(0, 99) == 0);
      config_write = ($urandom_range(0, 3) == 0);
      config_addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'(CFG + $urandom_range(0, 8 * TC - 1));
      config_data  = 36'({$urandom, $urandom});
      da_in = pick_op(); db_in = pick_op(); a_in = pick_op(); b_in = pick_op();
      annul = ($urandom_range(0, 3) == 0);
      tick();
    end
    reset = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/operand_address_translator.md
# operand_address_translator

Per-thread operand address translator sitting directly downstream of the control path's instruction fetch/decode stage. It consumes the decoded D, A and B operand addresses (DA, DB, A, B) and ALU_control each cycle, and applies per-thread addressing: a default base offset for private memory, plus indirect pointer slots with post-increment. The translated addresses and the delayed ALU_control feed the data memory read stage two cycles later. Threads issue in strict round-robin, one per cycle.

## Interface

- ADDR_WIDTH, 10, width of every operand address (DA, DB, A, B)
- WORD_WIDTH, 36, config data width; low ADDR_WIDTH bits used
- OD_WORD_WIDTH, 20, ALU_control width (passed through)
- THREAD_COUNT, 8, number of threads; must be a power of two
- THREAD_COUNT_WIDTH, 3, log2(THREAD_COUNT)
- SHARED_LIMIT, 32, raw addresses below this are shared/I/O and are never offset
- PTR_BASE, 24, first raw address of the 2-entry pointer window (PTR_BASE, PTR_BASE+1); must satisfy PTR_BASE+1 < SHARED_LIMIT
- CFG_BASE, 512, base config address of the translator tables
- clock  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high
- config_write  in  1  table write enable
- config_addr  in  ADDR_WIDTH  table write address
- config_data  in  WORD_WIDTH  table write data
- ALU_control_in  in  OD_WORD_WIDTH  from fetch/decode
- DA_in, DB_in, A_in, B_in  in  ADDR_WIDTH each  raw operand addresses
- annul  in  1  current stage-2 instruction cancelled; suppresses post-increment
- ALU_control  out  OD_WORD_WIDTH  delayed pass-through
- DA, DB, A, B  out  ADDR_WIDTH each  translated addresses

## Operation

- Thread counter: reset to 0, increments every cycle, wraps THREAD_COUNT-1 -> 0. The input sampled in a cycle belongs to the counter's thread; the thread tag travels with the instruction down the pipeline.
- Per-thread table, all reset to 0: OFS[t], PTR0[t], PTR1[t], INC0[t], INC1[t] (INC values signed, two's complement, ADDR_WIDTH bits).
- Config write, when config_write=1 and CFG_BASE <= config_addr < CFG_BASE+8*THREAD_COUNT: t = (config_addr-CFG_BASE)>>3, k = low 3 bits. k=0 OFS, 1 PTR0, 2 PTR1, 3 INC0, 4 INC1, 5..7 ignored. Data = config_data[ADDR_WIDTH-1:0]. Addresses outside the range are ignored.
- Translation per operand x, priority order:
  - x == PTR_BASE -> PTR0[t].
  - x == PTR_BASE+1 -> PTR1[t].
  - x < SHARED_LIMIT -> x unchanged.
  - otherwise -> (x + OFS[t]) mod 2^ADDR_WIDTH.
- Post-increment at stage 2, when valid and annul=0: PTRn[t] <= (PTRn[t] + INCn[t]) mod 2^ADDR_WIDTH if any of DA, DB, A, B referenced slot n.
  - The increment is applied exactly once per instruction, regardless of how many operands referenced the slot.
  - All operands referencing the same slot in one instruction see the pre-increment value.
- Simultaneous config write and post-increment to the same PTRn[t]: the config write wins. Any other combination of write and increment both take effect.

## Timing

- Latency 2 cycles: inputs at cycle n produce outputs after the edge ending cycle n+1. Full throughput, no stalls, no handshake.
- Stage 1 registers the inputs and thread tag and reads the tables. Stage 2 computes and registers the outputs, and commits the pointer update.
- annul is sampled in the cycle the instruction occupies stage 2, i.e. the cycle before its outputs become visible.
- Table reads observe writes committed on earlier edges only, with no bypass of same-cycle writes. The exception is the same-thread increment: the next access to PTRn[t] comes THREAD_COUNT cycles later, which is ≥ 2, so the updated value is always seen.
- Reset state:
  - All outputs 0; stage-valid bits 0; thread counter 0; all tables 0.
  - Instructions in flight at reset are dropped and commit no increment.
  - The first valid output appears 2 cycles after reset deasserts.

## Test plan

- Offset: OFS[3]=100; thread 3 issues A_in=40, B_in=5 -> two cycles later A=140, B=5; DA/DB/A/B for other threads unaffected.
- Pointer post-increment: PTR0[1]=200, INC0[1]=4; thread 1 issues A_in=24 on three consecutive turns -> A=200, 204, 208; PTR0[1] reads back 212.
- Shared slot, single increment: PTR1[0]=50, INC1[0]=1; DA_in=A_in=B_in=25 -> DA=A=B=50, then PTR1[0]=51.
- Annul and wrap: PTR0[2]=1023, INC0[2]=1 (ADDR_WIDTH=10) with annul=1 -> A=1023, no change; repeat with annul=0 -> PTR0[2]=0. INC0[2]=0x3FF (−1) from 0 -> 1023.
- Write/increment collision: config write PTR0[5]=77 on the same edge that commits a thread-5 increment -> PTR0[5]=77.
- Reset mid-stream: assert reset with a pointer-referencing instruction in stage 2 -> all outputs 0, no increment committed, thread counter restarts at 0.
